// File: rtl/cpu_pkg.sv
// Shared LEGv8 encodings and control types for the fetch/control unit,
// the datapath and the testbench.
package cpu_pkg;

  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [10:0] OP_ADDS  = 11'b10101011000;
  localparam logic [10:0] OP_SUBS  = 11'b11101011000;
  localparam logic [10:0] OP_AND   = 11'b10001010000;
  localparam logic [10:0] OP_EOR   = 11'b11001010000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_LDURB = 11'b00111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_STURB = 11'b00111000000;
  localparam logic [8:0]  OP_MOVZ  = 9'b110100101;
  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;

  localparam logic [3:0] COND_LT = 4'hB;

  localparam logic [3:0] SIZE_NONE  = 4'd0;
  localparam logic [3:0] SIZE_BYTE  = 4'd1;
  localparam logic [3:0] SIZE_DWORD = 4'd8;

  typedef enum logic [2:0] {
    ALU_PASS_B = 3'b000,
    ALU_ADD    = 3'b010,
    ALU_SUB    = 3'b011,
    ALU_AND    = 3'b100,
    ALU_XOR    = 3'b110
  } alu_op_e;

  typedef enum logic [1:0] {
    BR_NONE,
    BR_UNCOND,
    BR_CBZ,
    BR_LT
  } br_kind_e;

  typedef struct packed {
    logic      reg2loc;
    logic      reg_write;
    logic      mem_write;
    logic      mem_to_reg;
    logic      alu_src;
    logic      imm_sel;
    logic      shift_sel;
    logic [3:0] size;
    alu_op_e   alu_op;
    br_kind_e  br_kind;
    logic      set_flags;
    logic      illegal;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational LEGv8 opcode decoder: opcode field and condition code in,
// datapath strobes, branch kind and illegal indication out.
module ctrl_decode
  import cpu_pkg::*;
(
  input  logic [10:0] opc,
  input  logic [3:0]  cond,
  output ctrl_t       ctrl
);

  always_comb begin
    // NOTE: every field gets a default up front so no path leaves a latch.
    ctrl = '0;
    if (opc[10:1] == OP_ADDI) begin
      ctrl.reg_write = 1'b1;
      ctrl.alu_src   = 1'b1;
      ctrl.imm_sel   = 1'b1;
      ctrl.alu_op    = ALU_ADD;
    end else if (opc == OP_ADDS || opc == OP_SUBS) begin
      ctrl.reg_write = 1'b1;
      ctrl.reg2loc   = 1'b1;
      ctrl.alu_op    = (opc == OP_SUBS) ? ALU_SUB : ALU_ADD;
      ctrl.set_flags = 1'b1;
    end else if (opc == OP_AND || opc == OP_EOR) begin
      ctrl.reg_write = 1'b1;
      ctrl.reg2loc   = 1'b1;
      ctrl.alu_op    = (opc == OP_EOR) ? ALU_XOR : ALU_AND;
    end else if (opc == OP_LDUR || opc == OP_LDURB) begin
      ctrl.reg_write  = 1'b1;
      ctrl.alu_src    = 1'b1;
      ctrl.mem_to_reg = 1'b1;
      ctrl.alu_op     = ALU_ADD;
      ctrl.size       = (opc == OP_LDUR) ? SIZE_DWORD : SIZE_BYTE;
    end else if (opc == OP_STUR || opc == OP_STURB) begin
      ctrl.mem_write = 1'b1;
      ctrl.alu_src   = 1'b1;
      ctrl.alu_op    = ALU_ADD;
      ctrl.size      = (opc == OP_STUR) ? SIZE_DWORD : SIZE_BYTE;
    end else if (opc[10:2] == OP_MOVZ) begin
      ctrl.reg_write = 1'b1;
      ctrl.alu_src   = 1'b1;
      ctrl.shift_sel = 1'b1;
      ctrl.alu_op    = ALU_PASS_B;
    end else if (opc[10:5] == OP_B) begin
      ctrl.br_kind = BR_UNCOND;
    end else if (opc[10:3] == OP_CBZ) begin
      ctrl.br_kind = BR_CBZ;
      ctrl.alu_op  = ALU_PASS_B;
    end else if (opc[10:3] == OP_BCOND) begin
      // Only B.LT is implemented; other conditions are treated as unknown.
      if (cond == COND_LT) ctrl.br_kind = BR_LT;
      else                 ctrl.illegal = 1'b1;
    end else begin
      ctrl.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// LEGv8 single-cycle fetch/control: PC register, instruction decode,
// NZVC flag register and next-PC selection.
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] pc,
  input  logic [31:0]     instr,
  input  logic            imem_valid,
  input  logic            zero,
  input  logic            negative,
  input  logic            overflow,
  input  logic            carry_out,
  output logic [4:0]      Rd,
  output logic [4:0]      Rn,
  output logic [4:0]      Rm,
  output logic            Reg2Loc,
  output logic            RegWrite,
  output logic            MemWrite,
  output logic            MemToReg,
  output logic            ALUsrc,
  output logic            immSel,
  output logic            shiftSel,
  output logic [3:0]      LDURBsel,
  output logic [2:0]      ALUop,
  output logic [8:0]      DAddr9,
  output logic [11:0]     Imm12,
  output logic [15:0]     Imm16,
  output logic [1:0]      SHAMT,
  output logic [3:0]      flags_q,
  output logic            illegal
);

  ctrl_t           ctrl;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [3:0]      flags_d;
  logic            illegal_q, illegal_d;
  logic [PC_W-1:0] b_off, c_off, target, pc_plus4;
  logic            taken;

  ctrl_decode u_decode (
    .opc  (instr[31:21]),
    .cond (instr[3:0]),
    .ctrl (ctrl)
  );

  assign Rd       = instr[4:0];
  assign Rn       = instr[9:5];
  assign Rm       = instr[20:16];
  assign DAddr9   = instr[20:12];
  assign Imm12    = instr[21:10];
  assign Imm16    = instr[20:5];
  assign SHAMT    = instr[22:21];
  assign Reg2Loc  = ctrl.reg2loc;
  assign MemToReg = ctrl.mem_to_reg;
  assign ALUsrc   = ctrl.alu_src;
  assign immSel   = ctrl.imm_sel;
  assign shiftSel = ctrl.shift_sel;
  assign LDURBsel = ctrl.size;
  assign ALUop    = ctrl.alu_op;
  // A stalled fetch must never commit register or memory writes.
  assign RegWrite = ctrl.reg_write & imem_valid;
  assign MemWrite = ctrl.mem_write & imem_valid;
  assign pc       = pc_q;
  assign illegal  = illegal_q;

  always_comb begin
    pc_plus4 = pc_q + PC_W'(4);
    b_off    = {{(PC_W-28){instr[25]}}, instr[25:0], 2'b00};
    c_off    = {{(PC_W-21){instr[23]}}, instr[23:5], 2'b00};
    target   = pc_q + ((ctrl.br_kind == BR_UNCOND) ? b_off : c_off);
    unique case (ctrl.br_kind)
      BR_UNCOND: taken = 1'b1;
      BR_CBZ:    taken = zero;
      BR_LT:     taken = flags_q[3] ^ flags_q[1];
      default:   taken = 1'b0;
    endcase

    pc_d      = pc_q;
    flags_d   = flags_q;
    illegal_d = illegal_q;
    if (imem_valid) begin
      pc_d = taken ? target : pc_plus4;
      if (ctrl.set_flags) flags_d = {negative, zero, overflow, carry_out};
      if (ctrl.illegal)   illegal_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      flags_q   <= 4'b0000;
      illegal_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: decode table, directed sequences and
// randomized programs against an instruction-level reference model.
module tb_fetch_ctrl;
  import cpu_pkg::*;

  logic        clk, reset, imem_valid;
  logic [63:0] pc;
  logic [31:0] instr;
  logic        zero, negative, overflow, carry_out;
  logic [4:0]  Rd, Rn, Rm;
  logic        Reg2Loc, RegWrite, MemWrite, MemToReg, ALUsrc, immSel, shiftSel;
  logic [3:0]  LDURBsel;
  logic [2:0]  ALUop;
  logic [8:0]  DAddr9;
  logic [11:0] Imm12;
  logic [15:0] Imm16;
  logic [1:0]  SHAMT;
  logic [3:0]  flags_q;
  logic        illegal;

  fetch_ctrl #(.PC_W(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .pc(pc), .instr(instr), .imem_valid(imem_valid),
    .zero(zero), .negative(negative), .overflow(overflow), .carry_out(carry_out),
    .Rd(Rd), .Rn(Rn), .Rm(Rm), .Reg2Loc(Reg2Loc), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .MemToReg(MemToReg), .ALUsrc(ALUsrc), .immSel(immSel),
    .shiftSel(shiftSel), .LDURBsel(LDURBsel), .ALUop(ALUop), .DAddr9(DAddr9),
    .Imm12(Imm12), .Imm16(Imm16), .SHAMT(SHAMT), .flags_q(flags_q),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I_ADDI = 32'h910017E1;
  localparam logic [31:0] I_B3   = 32'h14000003;
  localparam logic [31:0] I_CBZ  = 32'hB4FFFFC2;
  localparam logic [31:0] I_SUBS = 32'hEB020023;
  localparam logic [31:0] I_BLT  = 32'h5400008B;
  localparam logic [31:0] I_STUR = 32'hF8000041;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic v, input logic [3:0] nzvc);
    instr      = i;
    imem_valid = v;
    negative   = nzvc[3];
    zero       = nzvc[2];
    overflow   = nzvc[1];
    carry_out  = nzvc[0];
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    imem_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  strobes;  // {RegWrite,MemWrite,MemToReg,ALUsrc,immSel,shiftSel,Reg2Loc}
    logic [2:0]  alu_op;
    logic [3:0]  size;
  } vec_t;

  vec_t vecs[15];

  // Reference model state
  logic [63:0] m_pc;
  logic [3:0]  m_flags;
  logic        m_ill;

  initial begin
    reset = 1'b0; instr = '0; imem_valid = 1'b0;
    zero = 1'b0; negative = 1'b0; overflow = 1'b0; carry_out = 1'b0;

    vecs[0]  = '{I_ADDI,       7'b1001100, 3'b010, 4'd0};
    vecs[1]  = '{32'hAB030041, 7'b1000001, 3'b010, 4'd0};
    vecs[2]  = '{I_SUBS,       7'b1000001, 3'b011, 4'd0};
    vecs[3]  = '{32'h8A030041, 7'b1000001, 3'b100, 4'd0};
    vecs[4]  = '{32'hCA030041, 7'b1000001, 3'b110, 4'd0};
    vecs[5]  = '{32'hF8400041, 7'b1011000, 3'b010, 4'd8};
    vecs[6]  = '{32'h38400041, 7'b1011000, 3'b010, 4'd1};
    vecs[7]  = '{I_STUR,       7'b0101000, 3'b010, 4'd8};
    vecs[8]  = '{32'h38000041, 7'b0101000, 3'b010, 4'd1};
    vecs[9]  = '{32'hD2800021, 7'b1001010, 3'b000, 4'd0};
    vecs[10] = '{I_B3,         7'b0000000, 3'b000, 4'd0};
    vecs[11] = '{I_CBZ,        7'b0000000, 3'b000, 4'd0};
    vecs[12] = '{I_BLT,        7'b0000000, 3'b000, 4'd0};
    vecs[13] = '{32'h54000080, 7'b0000000, 3'b000, 4'd0};
    vecs[14] = '{32'hFFFFFFFF, 7'b0000000, 3'b000, 4'd0};

    // Reset state and ADDI
    do_reset();
    check("reset pc", pc, 64'h0);
    check("reset flags", flags_q, 4'h0);
    check("reset illegal", illegal, 1'b0);
    drive(I_ADDI, 1'b1, 4'h0);
    check("addi Rd", Rd, 5'd1);
    check("addi Rn", Rn, 5'd31);
    check("addi Imm12", Imm12, 12'd5);
    check("addi strobes", {RegWrite, ALUsrc, immSel, MemWrite}, 4'b1110);
    check("addi ALUop", ALUop, 3'b010);
    tick();
    check("addi pc", pc, 64'h4);

    // Unconditional branch
    drive(I_B3, 1'b1, 4'h0); tick();
    check("b pc 4->10", pc, 64'h10);
    drive(I_B3, 1'b1, 4'h0);
    check("b no writes", {RegWrite, MemWrite}, 2'b00);
    tick();
    check("b pc 10->1c", pc, 64'h1C);

    // CBZ taken / not taken
    drive(I_ADDI, 1'b1, 4'h0); tick();
    drive(I_CBZ, 1'b1, 4'b0100);
    check("cbz taken Reg2Loc", Reg2Loc, 1'b0);
    tick();
    check("cbz taken pc", pc, 64'h18);
    drive(I_ADDI, 1'b1, 4'h0); tick();
    drive(I_ADDI, 1'b1, 4'h0); tick();
    check("pc before cbz", pc, 64'h20);
    drive(I_CBZ, 1'b1, 4'b0000);
    check("cbz not taken Reg2Loc", Reg2Loc, 1'b0);
    tick();
    check("cbz not taken pc", pc, 64'h24);

    // SUBS then B.LT, taken and not taken
    drive(32'h14000006, 1'b1, 4'h0); tick();
    check("b to 3c", pc, 64'h3C);
    drive(I_SUBS, 1'b1, 4'b1000); tick();
    check("subs flags N", flags_q, 4'b1000);
    drive(I_BLT, 1'b1, 4'h0); tick();
    check("blt taken pc", pc, 64'h50);
    drive(32'h17FFFFFB, 1'b1, 4'h0); tick();
    check("b back to 3c", pc, 64'h3C);
    drive(I_SUBS, 1'b1, 4'b1010); tick();
    check("subs flags NV", flags_q, 4'b1010);
    drive(I_BLT, 1'b1, 4'h0); tick();
    check("blt not taken pc", pc, 64'h44);

    // Stall
    do_reset();
    drive(I_ADDI, 1'b1, 4'h0); tick();
    drive(I_ADDI, 1'b1, 4'h0); tick();
    check("pc before stall", pc, 64'h8);
    for (int k = 0; k < 3; k++) begin
      drive((k == 0) ? I_SUBS : (k == 1) ? I_STUR : I_ADDI, 1'b0, 4'hF);
      check($sformatf("stall%0d writes", k), {RegWrite, MemWrite}, 2'b00);
      tick();
      check($sformatf("stall%0d pc", k), pc, 64'h8);
      check($sformatf("stall%0d flags", k), flags_q, 4'h0);
    end
    drive(I_ADDI, 1'b1, 4'h0); tick();
    check("resume pc", pc, 64'hC);

    // Illegal, sticky, then reset during a stall
    drive(32'hFFFFFFFF, 1'b1, 4'h0);
    check("illegal no writes", {RegWrite, MemWrite}, 2'b00);
    tick();
    check("illegal set", illegal, 1'b1);
    check("illegal pc", pc, 64'h10);
    drive(I_ADDI, 1'b1, 4'h0); tick();
    check("illegal sticky", illegal, 1'b1);
    drive(I_SUBS, 1'b1, 4'hF); tick();
    check("flags all", flags_q, 4'hF);
    drive(I_ADDI, 1'b0, 4'h0);
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst pc", pc, 64'h0);
    check("rst flags", flags_q, 4'h0);
    check("rst illegal", illegal, 1'b0);

    // Decode table
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].instr, 1'b1, 4'h0);
      check($sformatf("vec%0d strobes", i),
            {RegWrite, MemWrite, MemToReg, ALUsrc, immSel, shiftSel, Reg2Loc}, vecs[i].strobes);
      check($sformatf("vec%0d ALUop", i), ALUop, vecs[i].alu_op);
      check($sformatf("vec%0d LDURBsel", i), LDURBsel, vecs[i].size);
      tick();
    end

    // Randomized programs against the reference model
    do_reset();
    m_pc = 64'h0; m_flags = 4'h0; m_ill = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] r, ins;
      logic [3:0]  nzvc, c;
      logic        v, exp_rw, exp_mw;
      int          kind;
      longint      off;
      if ($urandom_range(0, 49) == 0) begin
        do_reset();
        m_pc = 64'h0; m_flags = 4'h0; m_ill = 1'b0;
        check("rand reset pc", pc, m_pc);
      end
      kind = $urandom_range(0, 12);
      r    = $urandom;
      nzvc = 4'($urandom_range(0, 15));
      v    = ($urandom_range(0, 7) != 0);
      c    = 4'($urandom_range(0, 10));
      case (kind)
        0:  ins = {OP_ADDI, r[21:0]};
        1:  ins = {OP_ADDS, r[20:0]};
        2:  ins = {OP_SUBS, r[20:0]};
        3:  ins = {OP_AND,  r[20:0]};
        4:  ins = {OP_EOR,  r[20:0]};
        5:  ins = {OP_LDUR, r[20:0]};
        6:  ins = {OP_STUR, r[20:0]};
        7:  ins = {OP_MOVZ, r[22:0]};
        8:  ins = {OP_B,    r[25:0]};
        9:  ins = {OP_CBZ,  r[23:0]};
        10: ins = {OP_BCOND, r[23:4], COND_LT};
        11: ins = {OP_BCOND, r[23:4], (c == COND_LT) ? 4'hC : c};
        default: ins = (r[1:0] == 2'd0) ? 32'h00000000 :
                       (r[1:0] == 2'd1) ? 32'h8B000000 : 32'hFFFFFFFF;
      endcase
      exp_rw = v && (kind inside {0, 1, 2, 3, 4, 5, 7});
      exp_mw = v && (kind == 6);
      drive(ins, v, nzvc);
      check($sformatf("rand%0d RegWrite", n), RegWrite, exp_rw);
      check($sformatf("rand%0d MemWrite", n), MemWrite, exp_mw);
      tick();
      if (v) begin
        off = 4;
        if (kind == 8) off = longint'($signed(ins[25:0])) * 4;
        if ((kind == 9 && nzvc[2]) || (kind == 10 && (m_flags[3] != m_flags[1])))
          off = longint'($signed(ins[23:5])) * 4;
        m_pc = m_pc + 64'(off);
        if (kind == 1 || kind == 2) m_flags = nzvc;
        if (kind >= 11) m_ill = 1'b1;
      end
      check($sformatf("rand%0d pc", n), pc, m_pc);
      check($sformatf("rand%0d flags", n), flags_q, m_flags);
      check($sformatf("rand%0d illegal", n), illegal, m_ill);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction fetch and control unit for the single-cycle LEGv8 CPU. It drives the datapath's control and operand inputs:
- holds the program counter and presents it to instruction memory;
- decodes the returned 32-bit instruction into register addresses, immediates and control strobes;
- keeps the condition flags set by ADDS/SUBS;
- selects the next PC from the datapath's combinational ALU flags.

## Interface
Parameters:
- PC_W, 64, program-counter width
- RESET_PC, 64'h0, PC value loaded on reset

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- pc  out  PC_W  fetch address to instruction memory
- instr  in  32  instruction word at pc (combinational read)
- imem_valid  in  1  instr valid this cycle; 0 = stall
- zero, negative, overflow, carry_out  in  1 each  datapath ALU flags (combinational)
- Rd, Rn, Rm  out  5 each  instr[4:0], instr[9:5], instr[20:16]
- Reg2Loc  out  1  1 = Rm to read port B, 0 = Rd
- RegWrite, MemWrite, MemToReg, ALUsrc, immSel, shiftSel  out  1 each  datapath strobes
- LDURBsel  out  4  transfer size: 8 for LDUR/STUR, 1 for LDURB/STURB, 0 otherwise
- ALUop  out  3  000 pass B, 010 add, 011 sub, 100 and, 110 xor
- DAddr9  out  9  instr[20:12]
- Imm12  out  12  instr[21:10]
- Imm16  out  16  instr[20:5]
- SHAMT  out  2  instr[22:21]
- flags_q  out  4  registered {N,Z,V,C}
- illegal  out  1  sticky: an undecoded opcode was seen

## Operation
Decode, valid instruction (all unlisted strobes 0):
- ADDI, opcode [31:22] 1001000100: RegWrite, ALUsrc, immSel; ALUop add.
- ADDS / SUBS, opcode [31:21] 10101011000 / 11101011000: RegWrite, Reg2Loc; ALUop add / sub; load flags.
- AND / EOR, opcode 10001010000 / 11001010000: RegWrite, Reg2Loc; ALUop and / xor.
- LDUR / LDURB, opcode 11111000010 / 00111000010: RegWrite, ALUsrc, MemToReg; ALUop add; LDURBsel 8 / 1.
- STUR / STURB, opcode 11111000000 / 00111000000: MemWrite, ALUsrc, Reg2Loc=0; ALUop add; LDURBsel 8 / 1.
- MOVZ, opcode [31:23] 110100101: RegWrite, ALUsrc, shiftSel; ALUop pass B.
- B, opcode [31:26] 000101: no writes; target = pc + SE(instr[25:0])<<2.
- CBZ, opcode [31:24] 10110100: Reg2Loc=0; ALUop pass B. Taken when the zero input is 1; target = pc + SE(instr[23:5])<<2.
- B.cond, opcode [31:24] 01010100: only LT (instr[3:0]=4'hB) is supported. Taken when flags_q.N != flags_q.V. Any other cond is treated as illegal.
- Any other opcode: behaves as a NOP and sets `illegal`.
- Not taken, or non-branch instruction: next PC = pc + 4.
- imem_valid=0: RegWrite=MemWrite=0, PC, flags_q and illegal hold; all other outputs are don't-care.
- Flag capture uses the datapath flags of the same cycle's ADDS/SUBS.

## Timing
- Decode is combinational from instr, with zero-cycle latency. The datapath's writes occur at the same rising edge.
- Each rising edge with imem_valid=1: pc <= next PC. flags_q <= {negative, zero, overflow, carry_out} only if the instruction is ADDS/SUBS.
- A B.LT in the cycle after SUBS sees the SUBS flags. A B.LT in the same cycle as flag capture cannot occur, because one instruction executes per cycle.
- Reset has priority over everything. On reset: pc=RESET_PC, flags_q=0, illegal=0. Decode outputs follow instr combinationally; the bench holds imem_valid=0 during reset.
- Reset asserted mid-stall or mid-program: state is reloaded at the next edge, with no partial update.
- Branch arithmetic is modulo 2^PC_W; wrap-around below 0 or above max is silent.
- Address width: 64. Branch offsets are sign-extended to PC_W before the shift.

## Structure
- `cpu_pkg`: opcode constants, ALUop enum, LDURBsel size constants, COND_LT. It is shared with the datapath and the testbench.
- Sub-module `ctrl_decode`: purely combinational, instr -> strobes, branch kind, and an illegal flag.
- Top level holds the PC register, flags register, illegal register and next-PC adder/mux.

## Test plan
- Reset, then instr=0x910017E1 (ADDI X1,X31,#5) with imem_valid=1: expect Rd=1, Rn=31, Imm12=5, RegWrite=1, ALUsrc=1, immSel=1, ALUop=010, and pc 0 -> 4.
- pc=0x10, instr=0x14000003 (B #3): expect next pc=0x1C, RegWrite=MemWrite=0.
- pc=0x20, instr=0xB4FFFFC2 (CBZ X2,#-2): with zero=1 expect pc=0x18; with zero=0 expect pc=0x24; Reg2Loc=0 in both cases.
- SUBS with negative=1, overflow=0 expects flags_q=4'b1000. Next cycle, instr=0x5400008B (B.LT #4) at pc=0x40 expects pc=0x50. Repeat with negative=overflow=1: expect pc=0x44.
- imem_valid=0 for 3 cycles at pc=0x8: pc stays 0x8 and RegWrite=MemWrite=0 throughout. Resume and pc=0xC.
- instr=0xFFFFFFFF: illegal=1 sticky and no writes. Then assert reset for 1 cycle: pc=0, flags_q=0, illegal=0.
